ccd_pattern_tx: RTL and testbench



---
 rtl/ccd_tx_pkg.sv | 54 +++++
 rtl/ccd_pattern_gen.sv | 38 +++
 rtl/ccd_pattern_tx.sv | 205 ++++++++++++++++++++
 tb/tb_ccd_pattern_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_tx_pkg.sv
// ccd_tx_pkg: shared types and constants for the CCD test-pattern transmitter.
//   state_e   - frame/line sequencer states
//   MODE_*    - pattern selector encodings (iMODE)
//   BAR_RGB   - 8-entry colour-bar table, {R,G,B} per bar, entry 0 = leftmost bar
//   bayer_e   - Bayer colour position of a pixel, derived from {y[0], x[0]}
package ccd_tx_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FPORCH = 3'd1,
        ST_LINE   = 3'd2,
        ST_HBLANK = 3'd3,
        ST_FTAIL  = 3'd4,
        ST_VBLANK = 3'd5
    } state_e;

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    // White, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101,
        3'b010, 3'b011, 3'b110, 3'b111
    };

    // Even row: G R G R ...   Odd row: B G B G ...
    typedef enum logic [1:0] {
        BAYER_GR = 2'b00,
        BAYER_R  = 2'b01,
        BAYER_B  = 2'b10,
        BAYER_GB = 2'b11
    } bayer_e;

    function automatic bayer_e bayer_pos(input logic x_lsb, input logic y_lsb);
        return bayer_e'({y_lsb, x_lsb});
    endfunction

    // Pick the RGB component that the given Bayer site samples.
    function automatic logic bayer_component(input logic [2:0] rgb, input bayer_e pos);
        logic comp;
        unique case (pos)
            BAYER_R:  comp = rgb[2];
            BAYER_B:  comp = rgb[0];
            BAYER_GR,
            BAYER_GB: comp = rgb[1];
        endcase
        return comp;
    endfunction

endpackage

// File: rtl/ccd_pattern_gen.sv
// ccd_pattern_gen: combinational pixel value for one raw Bayer sample.
//   x, y       - pixel coordinates of the sample being produced
//   bar        - colour-bar index of x (maintained by the caller without a divider)
//   mode       - latched pattern select (MODE_*)
//   const_val  - latched constant for MODE_CONST
//   pix_c      - pixel value (combinational)
module ccd_pattern_gen
    import ccd_tx_pkg::*;
#(
    parameter int unsigned DATA_W = 12
) (
    input  logic [CNT_W-1:0]  x,
    input  logic [CNT_W-1:0]  y,
    input  logic [2:0]        bar,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_val,
    output logic [DATA_W-1:0] pix_c
);

    logic [CNT_W-1:0] ramp_sum;
    logic             bar_bit;
    logic             check_bit;

    // Pattern select
    always_comb begin
        ramp_sum  = x + y;
        bar_bit   = bayer_component(BAR_RGB[bar], bayer_pos(x[0], y[0]));
        check_bit = x[4] ^ y[4];
        pix_c     = '0;
        unique case (mode)
            MODE_BARS:  pix_c = bar_bit ? '1 : '0;
            MODE_RAMP:  pix_c = DATA_W'(ramp_sum);
            MODE_CHECK: pix_c = check_bit ? '1 : '0;
            MODE_CONST: pix_c = const_val;
        endcase
    end

endmodule

// File: rtl/ccd_pattern_tx.sv
// ccd_pattern_tx: D8M-style raw Bayer camera source driven by internal test patterns.
//   iCLK, iRST       - pixel clock, synchronous active-high reset
//   iEN              - run request, sampled in IDLE and at the end of each vertical blank
//   iMODE, iCONST    - pattern select and constant, latched on FVAL rise
//   oDATA            - raw pixel, non-zero only while oLVAL=1
//   oFVAL, oLVAL     - frame / line valid
//   oX_Cont, oY_Cont - pixel and line index within the frame
//   oFrame_Cont      - completed-frame count (increments on FVAL fall)
//   oBUSY            - sequencer is not idle
// Every output is a flop; next values are computed for the state being entered.
module ccd_pattern_tx
    import ccd_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 160,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned F2L      = 8,
    parameter int unsigned L2F      = 8,
    parameter int unsigned V_BLANK  = 2000,
    parameter int unsigned DATA_W   = 12
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iEN,
    input  logic [1:0]        iMODE,
    input  logic [DATA_W-1:0] iCONST,
    output logic [DATA_W-1:0] oDATA,
    output logic              oFVAL,
    output logic              oLVAL,
    output logic [CNT_W-1:0]  oX_Cont,
    output logic [CNT_W-1:0]  oY_Cont,
    output logic [CNT_W-1:0]  oFrame_Cont,
    output logic              oBUSY
);

    localparam int unsigned BAR_W  = H_ACTIVE / 8;
    localparam int unsigned BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam int unsigned MAX_A  = (F2L > L2F) ? F2L : L2F;
    localparam int unsigned MAX_B  = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int unsigned PH_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CYC_W  = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [CNT_W-1:0]  X_LAST   = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  Y_LAST   = CNT_W'(V_ACTIVE - 1);
    localparam logic [BAR_CW-1:0] SUB_LAST = BAR_CW'(BAR_W - 1);
    localparam logic [CYC_W-1:0]  F2L_LAST = CYC_W'(F2L - 1);
    localparam logic [CYC_W-1:0]  HB_LAST  = CYC_W'(H_BLANK - 1);
    localparam logic [CYC_W-1:0]  L2F_LAST = CYC_W'(L2F - 1);
    localparam logic [CYC_W-1:0]  VB_LAST  = CYC_W'(V_BLANK - 1);

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   x_q, x_d;
    logic [CNT_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic [2:0]         bar_q, bar_d;
    logic [BAR_CW-1:0]  sub_q, sub_d;
    logic [1:0]         mode_q, mode_d;
    logic [DATA_W-1:0]  const_q, const_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               fval_q, fval_d;
    logic               lval_q, lval_d;
    logic               busy_q, busy_d;
    logic               start;
    logic [DATA_W-1:0]  pix_c;

    // State and output registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
            bar_q   <= '0;
            sub_q   <= '0;
            mode_q  <= '0;
            const_q <= '0;
            data_q  <= '0;
            fval_q  <= 1'b0;
            lval_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            bar_q   <= bar_d;
            sub_q   <= sub_d;
            mode_q  <= mode_d;
            const_q <= const_d;
            data_q  <= data_d;
            fval_q  <= fval_d;
            lval_q  <= lval_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + CYC_W'(1);
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        bar_d   = bar_q;
        sub_d   = sub_q;
        mode_d  = mode_q;
        const_d = const_q;
        start   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cyc_d = '0;
                if (iEN) start = 1'b1;
            end
            ST_FPORCH: begin
                if (cyc_q == F2L_LAST) begin
                    state_d = ST_LINE;
                    x_d     = '0;
                    bar_d   = '0;
                    sub_d   = '0;
                end
            end
            ST_LINE: begin
                if (x_q == X_LAST) begin
                    cyc_d   = '0;
                    state_d = (y_q < Y_LAST) ? ST_HBLANK : ST_FTAIL;
                end else begin
                    x_d = x_q + CNT_W'(1);
                    // Bar index advances every BAR_W pixels
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        bar_d = bar_q + 3'd1;
                    end else begin
                        sub_d = sub_q + BAR_CW'(1);
                    end
                end
            end
            ST_HBLANK: begin
                if (cyc_q == HB_LAST) begin
                    state_d = ST_LINE;
                    y_d     = y_q + CNT_W'(1);
                    x_d     = '0;
                    bar_d   = '0;
                    sub_d   = '0;
                end
            end
            ST_FTAIL: begin
                if (cyc_q == L2F_LAST) begin
                    state_d = ST_VBLANK;
                    cyc_d   = '0;
                    frame_d = frame_q + CNT_W'(1);
                end
            end
            ST_VBLANK: begin
                if (cyc_q == VB_LAST) begin
                    if (iEN) start = 1'b1;
                    else     state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame start: FVAL rises, counters clear, pattern settings latch
        if (start) begin
            state_d = ST_FPORCH;
            cyc_d   = '0;
            x_d     = '0;
            y_d     = '0;
            mode_d  = iMODE;
            const_d = iCONST;
        end

        fval_d = (state_d == ST_FPORCH) || (state_d == ST_LINE) ||
                 (state_d == ST_HBLANK) || (state_d == ST_FTAIL);
        lval_d = (state_d == ST_LINE);
        busy_d = (state_d != ST_IDLE);
    end

    // Pixel for the coordinates being entered; F2L>=1 guarantees mode_q is already latched
    ccd_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_gen (
        .x         (x_d),
        .y         (y_d),
        .bar       (bar_d),
        .mode      (mode_q),
        .const_val (const_q),
        .pix_c     (pix_c)
    );

    assign data_d = lval_d ? pix_c : '0;

    assign oDATA       = data_q;
    assign oFVAL       = fval_q;
    assign oLVAL       = lval_q;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oFrame_Cont = frame_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_ccd_pattern_tx.sv
// tb_ccd_pattern_tx: small-geometry instance (8x4) under directed + random control,
// plus a 32x32 instance free-running the checkerboard. Both are compared every cycle
// against a frame-timing model computed from the cycle index within the frame.
module tb_ccd_pattern_tx;

    localparam int H0  = 8;
    localparam int V0  = 4;
    localparam int H1  = 32;
    localparam int V1  = 32;
    localparam int HB  = 4;
    localparam int F2L = 2;
    localparam int L2F = 2;
    localparam int VB  = 6;

    logic        clk;
    logic        rst0, en0, rst1, en1;
    logic [1:0]  mode0, mode1;
    logic [11:0] cv0, cv1;
    logic [11:0] data0, data1;
    logic        fval0, lval0, busy0, fval1, lval1, busy1;
    logic [15:0] x0, y0, fc0, x1, y1, fc1;

    ccd_pattern_tx #(
        .H_ACTIVE (H0), .H_BLANK (HB), .V_ACTIVE (V0),
        .F2L (F2L), .L2F (L2F), .V_BLANK (VB), .DATA_W (12)
    ) u_dut (
        .iCLK (clk), .iRST (rst0), .iEN (en0), .iMODE (mode0), .iCONST (cv0),
        .oDATA (data0), .oFVAL (fval0), .oLVAL (lval0), .oX_Cont (x0),
        .oY_Cont (y0), .oFrame_Cont (fc0), .oBUSY (busy0)
    );

    ccd_pattern_tx #(
        .H_ACTIVE (H1), .H_BLANK (HB), .V_ACTIVE (V1),
        .F2L (F2L), .L2F (L2F), .V_BLANK (VB), .DATA_W (12)
    ) u_dut_big (
        .iCLK (clk), .iRST (rst1), .iEN (en1), .iMODE (mode1), .iCONST (cv1),
        .oDATA (data1), .oFVAL (fval1), .oLVAL (lval1), .oX_Cont (x1),
        .oY_Cont (y1), .oFrame_Cont (fc1), .oBUSY (busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    int run0     = 0;

    // Reference model state, one slot per instance
    bit m_idle[2]     = '{1, 1};
    bit m_rst_seen[2] = '{1, 1};
    int m_t[2]        = '{0, 0};
    int m_x[2]        = '{0, 0};
    int m_y[2]        = '{0, 0};
    int m_frame[2]    = '{0, 0};
    int m_mode[2]     = '{0, 0};
    int m_cv[2]       = '{0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int geo_h(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    function automatic int geo_v(input int i);
        return (i == 0) ? V0 : V1;
    endfunction

    function automatic int f_hi(input int i);
        return F2L + geo_v(i) * geo_h(i) + (geo_v(i) - 1) * HB + L2F;
    endfunction

    function automatic bit exp_lval(input int i);
        int p;
        if (m_idle[i] || m_t[i] >= f_hi(i) || m_t[i] < F2L) return 0;
        p = m_t[i] - F2L;
        return (p < geo_v(i) * (geo_h(i) + HB)) && ((p % (geo_h(i) + HB)) < geo_h(i));
    endfunction

    function automatic bit exp_fval(input int i);
        return !m_idle[i] && (m_t[i] < f_hi(i));
    endfunction

    function automatic int exp_data(input int i);
        int bars[8];
        int rgb, x, y, comp;
        bars = '{7, 6, 3, 2, 5, 4, 1, 0};
        if (!exp_lval(i)) return 0;
        x = m_x[i];
        y = m_y[i];
        case (m_mode[i])
            0: begin
                rgb = bars[x / (geo_h(i) / 8)];
                if (y % 2 == 0) comp = (x % 2 == 0) ? (rgb >> 1) & 1 : (rgb >> 2) & 1;
                else            comp = (x % 2 == 0) ? rgb & 1 : (rgb >> 1) & 1;
                return comp ? 'hFFF : 0;
            end
            1: return (x + y) % 4096;
            2: return (((x / 16) + (y / 16)) % 2 == 1) ? 'hFFF : 0;
            default: return m_cv[i];
        endcase
    endfunction

    task automatic model_start(input int i, input int mode, input int cv);
        m_idle[i] = 0;
        m_t[i]    = 0;
        m_x[i]    = 0;
        m_y[i]    = 0;
        m_mode[i] = mode;
        m_cv[i]   = cv;
    endtask

    task automatic model_step(input int i, input bit rst, input bit en, input int mode, input int cv);
        int p;
        m_rst_seen[i] = rst;
        if (rst) begin
            m_idle[i] = 1; m_t[i] = 0; m_x[i] = 0; m_y[i] = 0;
            m_frame[i] = 0; m_mode[i] = 0; m_cv[i] = 0;
        end else if (m_idle[i]) begin
            if (en) model_start(i, mode, cv);
        end else if (m_t[i] == f_hi(i) + VB - 1) begin
            if (en) model_start(i, mode, cv);
            else    m_idle[i] = 1;
        end else begin
            m_t[i]++;
            if (m_t[i] == f_hi(i)) m_frame[i] = (m_frame[i] + 1) % 65536;
        end
        if (exp_lval(i)) begin
            p = m_t[i] - F2L;
            m_x[i] = p % (geo_h(i) + HB);
            m_y[i] = p / (geo_h(i) + HB);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        model_step(0, rst0, en0, int'(mode0), int'(cv0));
        model_step(1, rst1, en1, int'(mode1), int'(cv1));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("fval0",  32'(fval0), 32'(exp_fval(0)));
            check("lval0",  32'(lval0), 32'(exp_lval(0)));
            check("data0",  32'(data0), 32'(exp_data(0)));
            check("x0",     32'(x0),    32'(m_x[0]));
            check("y0",     32'(y0),    32'(m_y[0]));
            check("frame0", 32'(fc0),   32'(m_frame[0]));
            check("busy0",  32'(busy0), 32'(!m_idle[0]));
            check("fval1",  32'(fval1), 32'(exp_fval(1)));
            check("lval1",  32'(lval1), 32'(exp_lval(1)));
            check("data1",  32'(data1), 32'(exp_data(1)));
            check("x1",     32'(x1),    32'(m_x[1]));
            check("y1",     32'(y1),    32'(m_y[1]));
            check("frame1", 32'(fc1),   32'(m_frame[1]));
            // Natural FVAL-high length: F2L + V*H + (V-1)*HB + L2F
            if (fval0) begin
                run0++;
            end else begin
                if (run0 != 0 && !m_rst_seen[0])
                    check("fval_len", 32'(run0), 32'(F2L + V0 * H0 + (V0 - 1) * HB + L2F));
                run0 = 0;
            end
        end
    end

    initial begin
        int cnt;
        rst0 = 1; rst1 = 1; en0 = 0; en1 = 0;
        mode0 = 2'd3; cv0 = 12'h5A5; mode1 = 2'd2; cv1 = 12'h000;
        repeat (2) @(negedge clk);
        chk_en = 1;
        rst0 = 0; rst1 = 0; en0 = 1; en1 = 1;

        // Constant, bars, ramp, each re-latched at a frame start
        repeat (3 * 54) @(negedge clk);
        mode0 = 2'd0;
        repeat (2 * 54) @(negedge clk);
        mode0 = 2'd1;
        repeat (2 * 54) @(negedge clk);

        // Stop request mid-frame with a mode change
        cnt = 0;
        while (!(lval0 && y0 == 16'd1) && cnt < 400) begin @(negedge clk); cnt++; end
        check("stop_wait_lval", 32'(lval0), 32'd1);
        en0 = 0; mode0 = 2'd3; cv0 = 12'h123;
        cnt = 0;
        while (busy0 && cnt < 200) begin @(negedge clk); cnt++; end
        check("stop_busy", 32'(busy0), 32'd0);
        check("stop_fval", 32'(fval0), 32'd0);
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy0), 32'd0);
        mode0 = 2'd1; en0 = 1;
        @(negedge clk);
        check("restart_fval", 32'(fval0), 32'd1);
        check("restart_x",    32'(x0),    32'd0);

        // Reset in the middle of a line
        cnt = 0;
        while (!(lval0 && x0 == 16'd3) && cnt < 400) begin @(negedge clk); cnt++; end
        check("rst_wait_x", 32'(x0), 32'd3);
        rst0 = 1;
        @(negedge clk);
        check("rst_fval",  32'(fval0), 32'd0);
        check("rst_lval",  32'(lval0), 32'd0);
        check("rst_data",  32'(data0), 32'd0);
        check("rst_x",     32'(x0),    32'd0);
        check("rst_y",     32'(y0),    32'd0);
        check("rst_frame", 32'(fc0),   32'd0);
        check("rst_busy",  32'(busy0), 32'd0);
        rst0 = 0; en0 = 1;
        @(negedge clk);
        check("rst_restart_fval",  32'(fval0), 32'd1);
        check("rst_restart_y",     32'(y0),    32'd0);
        check("rst_restart_frame", 32'(fc0),   32'd0);

        // Random control traffic
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) en0 = ~en0;
            if ($urandom_range(0, 59) == 0)  mode0 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0)  cv0 = 12'($urandom);
            rst0 = ($urandom_range(0, 799) == 0);
        end
        rst0 = 0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
